// File: rtl/sensor_frame_sched.sv
// Frame/line timing scheduler: fval/lval generation plus a multi-channel ramp pixel stream.
// Define SENSOR_TRIGGER_EN to start each frame only on a pending i_trigger rising edge.
module sensor_frame_sched #(
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNEL_NUM = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              i_enable,
  input  logic [CNT_WIDTH-1:0]              iv_width,
  input  logic [CNT_WIDTH-1:0]              iv_height,
  input  logic [CNT_WIDTH-1:0]              iv_h_blank,
  input  logic [CNT_WIDTH-1:0]              iv_v_front,
  input  logic [CNT_WIDTH-1:0]              iv_v_tail,
  input  logic [CNT_WIDTH-1:0]              iv_v_blank,
  input  logic                              i_trigger,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic                              o_frame_done,
  output logic [CNT_WIDTH-1:0]              ov_frame_cnt
);

  localparam int SUM_WIDTH = CNT_WIDTH + 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRONT,
    ST_ACTIVE,
    ST_HBLANK,
    ST_TAIL,
    ST_VBLANK
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_WIDTH-1:0]    phase_reg, phase_next;
  logic [CNT_WIDTH-1:0]    line_cnt_reg, line_cnt_next;
  logic [CNT_WIDTH-1:0]    pix_cnt_reg, pix_cnt_next;

  logic [CNT_WIDTH-1:0]    width_reg, height_reg, h_blank_reg;
  logic [CNT_WIDTH-1:0]    v_front_reg, v_tail_reg, v_blank_reg;
  logic                    latch_cfg;

  logic                    fval_reg, lval_reg, frame_done_reg;
  logic [CNT_WIDTH-1:0]    frame_cnt_reg;
  logic [DATA_WIDTH*CHANNEL_NUM-1:0] pix_data_reg, pix_data_next;

  logic                    trig_ok;
  logic                    start_ok;
  logic                    front_entry;

  // Phase counter is loaded with (length-1); a zero length behaves as one clock.
  function automatic logic [CNT_WIDTH-1:0] hold_len(input logic [CNT_WIDTH-1:0] len);
    return (len == '0) ? '0 : len - CNT_WIDTH'(1);
  endfunction

  assign front_entry = (state_next == ST_FRONT) && (state_reg != ST_FRONT);

`ifdef SENSOR_TRIGGER_EN
  logic trig_dly_reg;
  logic trig_pend_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_dly_reg  <= 1'b0;
      trig_pend_reg <= 1'b0;
    end else begin
      trig_dly_reg <= i_trigger;
      // A new rising edge wins over consumption so it is kept for the next frame.
      if (i_trigger && !trig_dly_reg)
        trig_pend_reg <= 1'b1;
      else if (front_entry)
        trig_pend_reg <= 1'b0;
    end
  end

  assign trig_ok = trig_pend_reg;
`else
  logic unused_trigger;
  assign unused_trigger = i_trigger;
  assign trig_ok        = 1'b1;
`endif

  // Validity is judged on the values being latched at this very edge.
  assign start_ok = i_enable && (iv_width != '0) && (iv_height != '0) && trig_ok;

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    line_cnt_next = line_cnt_reg;
    pix_cnt_next  = pix_cnt_reg;
    latch_cfg     = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        latch_cfg = 1'b1;
        if (start_ok) begin
          state_next    = ST_FRONT;
          phase_next    = hold_len(iv_v_front);
          line_cnt_next = '0;
        end
      end

      ST_FRONT: begin
        line_cnt_next = '0;
        if (phase_reg == '0) begin
          state_next   = ST_ACTIVE;
          phase_next   = width_reg - CNT_WIDTH'(1);
          pix_cnt_next = '0;
        end else begin
          phase_next = phase_reg - CNT_WIDTH'(1);
        end
      end

      ST_ACTIVE: begin
        if (phase_reg == '0) begin
          if (line_cnt_reg < height_reg - CNT_WIDTH'(1)) begin
            state_next    = ST_HBLANK;
            phase_next    = hold_len(h_blank_reg);
            line_cnt_next = line_cnt_reg + CNT_WIDTH'(1);
          end else begin
            state_next = ST_TAIL;
            phase_next = hold_len(v_tail_reg);
          end
        end else begin
          phase_next   = phase_reg - CNT_WIDTH'(1);
          pix_cnt_next = pix_cnt_reg + CNT_WIDTH'(1);
        end
      end

      ST_HBLANK: begin
        if (phase_reg == '0) begin
          state_next   = ST_ACTIVE;
          phase_next   = width_reg - CNT_WIDTH'(1);
          pix_cnt_next = '0;
        end else begin
          phase_next = phase_reg - CNT_WIDTH'(1);
        end
      end

      ST_TAIL: begin
        if (phase_reg == '0) begin
          state_next = ST_VBLANK;
          phase_next = hold_len(v_blank_reg);
        end else begin
          phase_next = phase_reg - CNT_WIDTH'(1);
        end
      end

      ST_VBLANK: begin
        if (phase_reg == '0) begin
          state_next = ST_IDLE;
          phase_next = '0;
          if (i_enable) begin
            latch_cfg = 1'b1;
            if (start_ok) begin
              state_next    = ST_FRONT;
              phase_next    = hold_len(iv_v_front);
              line_cnt_next = '0;
            end
          end
        end else begin
          phase_next = phase_reg - CNT_WIDTH'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
        phase_next = '0;
      end
    endcase
  end

  // Ramp value per channel, formed from the counters the next cycle will hold.
  generate
    for (genvar gi = 0; gi < CHANNEL_NUM; gi++) begin : g_chan
      logic [SUM_WIDTH-1:0] ramp_sum;
      assign ramp_sum = SUM_WIDTH'(pix_cnt_next) * SUM_WIDTH'(CHANNEL_NUM)
                      + SUM_WIDTH'(gi) + SUM_WIDTH'(line_cnt_next);
      assign pix_data_next[gi*DATA_WIDTH +: DATA_WIDTH] =
        (state_next == ST_ACTIVE) ? ramp_sum[DATA_WIDTH-1:0] : '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      phase_reg      <= '0;
      line_cnt_reg   <= '0;
      pix_cnt_reg    <= '0;
      width_reg      <= '0;
      height_reg     <= '0;
      h_blank_reg    <= '0;
      v_front_reg    <= '0;
      v_tail_reg     <= '0;
      v_blank_reg    <= '0;
      fval_reg       <= 1'b0;
      lval_reg       <= 1'b0;
      pix_data_reg   <= '0;
      frame_done_reg <= 1'b0;
      frame_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      line_cnt_reg <= line_cnt_next;
      pix_cnt_reg  <= pix_cnt_next;
      if (latch_cfg) begin
        width_reg   <= iv_width;
        height_reg  <= iv_height;
        h_blank_reg <= iv_h_blank;
        v_front_reg <= iv_v_front;
        v_tail_reg  <= iv_v_tail;
        v_blank_reg <= iv_v_blank;
      end
      fval_reg       <= (state_next == ST_FRONT) || (state_next == ST_ACTIVE) ||
                        (state_next == ST_HBLANK) || (state_next == ST_TAIL);
      lval_reg       <= (state_next == ST_ACTIVE);
      pix_data_reg   <= pix_data_next;
      frame_done_reg <= (state_reg == ST_TAIL) && (state_next == ST_VBLANK);
      if ((state_reg == ST_TAIL) && (state_next == ST_VBLANK))
        frame_cnt_reg <= frame_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign o_fval       = fval_reg;
  assign o_lval       = lval_reg;
  assign ov_pix_data  = pix_data_reg;
  assign o_frame_done = frame_done_reg;
  assign ov_frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_sensor_frame_sched.sv
// Directed testbench for sensor_frame_sched: frame timing, ramp data, enable/settings latching, reset.
// Build with SENSOR_TRIGGER_EN defined to exercise the single-frame trigger path instead.
module tb_sensor_frame_sched;

  localparam int DW = 8;
  localparam int CH = 4;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           i_enable;
  logic [CW-1:0]  iv_width, iv_height, iv_h_blank, iv_v_front, iv_v_tail, iv_v_blank;
  logic           i_trigger;
  logic           o_fval, o_lval, o_frame_done;
  logic [DW*CH-1:0] ov_pix_data;
  logic [CW-1:0]  ov_frame_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  sensor_frame_sched #(.DATA_WIDTH(DW), .CHANNEL_NUM(CH), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_enable     (i_enable),
    .iv_width     (iv_width),
    .iv_height    (iv_height),
    .iv_h_blank   (iv_h_blank),
    .iv_v_front   (iv_v_front),
    .iv_v_tail    (iv_v_tail),
    .iv_v_blank   (iv_v_blank),
    .i_trigger    (i_trigger),
    .o_fval       (o_fval),
    .o_lval       (o_lval),
    .ov_pix_data  (ov_pix_data),
    .o_frame_done (o_frame_done),
    .ov_frame_cnt (ov_frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_basic();
    iv_width = 4; iv_height = 2; iv_h_blank = 2; iv_v_front = 3; iv_v_tail = 1; iv_v_blank = 2;
  endtask

  // Called on the first negedge with fval high; walks the frame through the end of VBLANK.
  task automatic check_frame(input int w, input int h, input int hb, input int vf, input int vt,
                             input int vb, input int exp_cnt, input int drop_t, input int wr_t,
                             input int wr_w, input int trig_t);
    int f_len, hb_len, t_len, vb_len, body, flen, u, line, off, errs;
    logic exp_f, exp_l;
    logic [DW*CH-1:0] exp_d;
    f_len  = (vf < 1) ? 1 : vf;
    hb_len = (hb < 1) ? 1 : hb;
    t_len  = (vt < 1) ? 1 : vt;
    vb_len = (vb < 1) ? 1 : vb;
    body   = h * w + (h - 1) * hb_len;
    flen   = f_len + body + t_len;
    errs   = n_checks - n_pass;
    for (int t = 0; t < flen + vb_len; t++) begin
      exp_f = (t < flen);
      exp_l = 1'b0;
      exp_d = '0;
      u = t - f_len;
      if (u >= 0 && u < body) begin
        line = u / (w + hb_len);
        off  = u % (w + hb_len);
        if (off < w) begin
          exp_l = 1'b1;
          for (int c = 0; c < CH; c++) exp_d[c*DW +: DW] = DW'(off * CH + c + line);
        end
      end
      n_checks++;
      if (o_fval !== exp_f) $display("FAIL fval t=%0d got %b want %b", t, o_fval, exp_f);
      else n_pass++;
      n_checks++;
      if (o_lval !== exp_l) $display("FAIL lval t=%0d got %b want %b", t, o_lval, exp_l);
      else n_pass++;
      n_checks++;
      if (ov_pix_data !== exp_d) $display("FAIL pix_data t=%0d got %h want %h", t, ov_pix_data, exp_d);
      else n_pass++;
      n_checks++;
      if (o_frame_done !== (t == flen))
        $display("FAIL frame_done t=%0d got %b want %b", t, o_frame_done, (t == flen));
      else n_pass++;
      if (t == flen - 1 || t == flen) begin
        n_checks++;
        if (ov_frame_cnt !== CW'((t == flen) ? exp_cnt : exp_cnt - 1))
          $display("FAIL frame_cnt t=%0d got %0d want %0d", t, ov_frame_cnt,
                   (t == flen) ? exp_cnt : exp_cnt - 1);
        else n_pass++;
      end
      if (t == drop_t) i_enable = 1'b0;
      if (t == wr_t) iv_width = CW'(wr_w);
      if (t == trig_t) i_trigger = 1'b1;
      if (t == trig_t + 1) i_trigger = 1'b0;
      @(negedge clk);
    end
    $display("frame w=%0d h=%0d cnt=%0d: %0d new errors", w, h, exp_cnt, (n_checks - n_pass) - errs);
  endtask

  task automatic check_idle(input int cycles, input int exp_cnt);
    int busy = 0;
    for (int i = 0; i < cycles; i++) begin
      if (o_fval !== 1'b0 || o_lval !== 1'b0) busy++;
      @(negedge clk);
    end
    n_checks++;
    if (busy != 0) $display("FAIL idle_quiet got %0d busy cycles want 0", busy);
    else n_pass++;
    n_checks++;
    if (ov_frame_cnt !== CW'(exp_cnt)) $display("FAIL idle_frame_cnt got %0d want %0d", ov_frame_cnt, exp_cnt);
    else n_pass++;
    $display("idle %0d cycles, frame_cnt=%0d", cycles, ov_frame_cnt);
  endtask

  task automatic check_start_latency();
    n_checks++;
    if (o_fval !== 1'b1) $display("FAIL start_latency got fval=%b want 1", o_fval);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_enable = 1'b0; i_trigger = 1'b0;
    set_basic();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_fval, o_lval, o_frame_done} !== 3'b000) $display("FAIL reset_flags got %b want 000", {o_fval, o_lval, o_frame_done});
    else n_pass++;
    n_checks++;
    if (ov_pix_data !== '0) $display("FAIL reset_pix got %h want 0", ov_pix_data);
    else n_pass++;
    n_checks++;
    if (ov_frame_cnt !== '0) $display("FAIL reset_cnt got %0d want 0", ov_frame_cnt);
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
    $display("reset released");
  endtask

`ifndef SENSOR_TRIGGER_EN
  task automatic test_basic_frame();
    set_basic();
    i_enable = 1'b1;
    @(negedge clk);
    check_start_latency();
    check_frame(4, 2, 2, 3, 1, 2, 1, -1, -1, 0, -1);
  endtask

  task automatic test_enable_drop();
    check_frame(4, 2, 2, 3, 1, 2, 2, 4, -1, 0, -1);
    check_idle(30, 2);
  endtask

  task automatic test_width_change();
    i_enable = 1'b1;
    @(negedge clk);
    check_start_latency();
    check_frame(4, 2, 2, 3, 1, 2, 3, -1, 5, 8, -1);
    check_frame(8, 2, 2, 3, 1, 2, 4, 5, -1, 0, -1);
    check_idle(5, 4);
    iv_width = 4;
  endtask

  task automatic test_single_line();
    iv_width = 3; iv_height = 1; iv_h_blank = 5; iv_v_front = 0; iv_v_tail = 0; iv_v_blank = 0;
    i_enable = 1'b1;
    @(negedge clk);
    check_start_latency();
    check_frame(3, 1, 5, 0, 0, 0, 5, 2, -1, 0, -1);
    check_idle(5, 5);
  endtask

  task automatic test_invalid_config();
    set_basic();
    iv_width = 0;
    i_enable = 1'b1;
    check_idle(10, 5);
    i_enable = 1'b0;
    set_basic();
  endtask

  task automatic test_reset_mid_active();
    set_basic();
    i_enable = 1'b1;
    @(negedge clk);
    check_start_latency();
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_lval !== 1'b1 || ov_pix_data !== 32'h03020100)
      $display("FAIL pre_reset_active got lval=%b data=%h want 1 03020100", o_lval, ov_pix_data);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({o_fval, o_lval, o_frame_done} !== 3'b000) $display("FAIL async_reset_flags got %b want 000", {o_fval, o_lval, o_frame_done});
    else n_pass++;
    n_checks++;
    if (ov_pix_data !== '0 || ov_frame_cnt !== '0)
      $display("FAIL async_reset_data got %h cnt %0d want 0 0", ov_pix_data, ov_frame_cnt);
    else n_pass++;
    i_enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_idle(10, 0);
    i_enable = 1'b1;
    @(negedge clk);
    check_start_latency();
    check_frame(4, 2, 2, 3, 1, 2, 1, 3, -1, 0, -1);
    check_idle(5, 1);
  endtask
`else
  task automatic wait_fval(input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      if (o_fval === 1'b1) seen = 1;
      else @(negedge clk);
    end
    n_checks++;
    if (seen == 0) $display("FAIL fval_rise got none want rise within %0d cycles", budget);
    else n_pass++;
  endtask

  task automatic test_trigger();
    set_basic();
    i_enable = 1'b1;
    check_idle(100, 0);
    i_enable = 1'b0;
    for (int p = 0; p < 3; p++) begin
      i_trigger = 1'b1; @(negedge clk);
      i_trigger = 1'b0; @(negedge clk);
    end
    i_enable = 1'b1;
    wait_fval(10);
    check_frame(4, 2, 2, 3, 1, 2, 1, -1, -1, 0, -1);
    check_idle(50, 1);
    i_trigger = 1'b1; @(negedge clk);
    i_trigger = 1'b0;
    wait_fval(10);
    check_frame(4, 2, 2, 3, 1, 2, 2, -1, -1, 0, 5);
    check_frame(4, 2, 2, 3, 1, 2, 3, -1, -1, 0, -1);
    check_idle(50, 3);
  endtask
`endif

  initial begin
    test_reset();
`ifndef SENSOR_TRIGGER_EN
    test_basic_frame();
    test_enable_drop();
    test_width_change();
    test_single_line();
    test_invalid_config();
    test_reset_mid_active();
`else
    test_trigger();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
